// File: rtl/game_flow_ctrl.sv
// Game-flow FSM for the obstacle game: menu, multi-level play, pause, per-death
// life loss, timed level-clear/lose screens and game-over/win screens.
module game_flow_ctrl #(
  parameter int NUM_LEVELS  = 3,
  parameter int MAX_LIVES   = 3,
  parameter int HOLD_CYCLES = 50,
  localparam int LVL_W  = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int LIFE_W = $clog2(MAX_LIVES + 1),
  localparam int CNT_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              userSel,
  input  logic              pauseBtn,
  input  logic              win,
  input  logic              dead,
  output logic              menuScreen,
  output logic              playEn,
  output logic              pauseScreen,
  output logic              clearScreen,
  output logic              loseScreen,
  output logic              overScreen,
  output logic              winScreen,
  output logic              levelLoad,
  output logic [LVL_W-1:0]  level,
  output logic [LIFE_W-1:0] lives
);

  localparam logic [2:0] ST_MENU     = 3'd0;
  localparam logic [2:0] ST_PLAY     = 3'd1;
  localparam logic [2:0] ST_PAUSE    = 3'd2;
  localparam logic [2:0] ST_CLEAR    = 3'd3;
  localparam logic [2:0] ST_LOSE     = 3'd4;
  localparam logic [2:0] ST_GAMEOVER = 3'd5;
  localparam logic [2:0] ST_WIN      = 3'd6;

  localparam logic [LVL_W-1:0]  LAST_LEVEL = LVL_W'(NUM_LEVELS - 1);
  localparam logic [LIFE_W-1:0] FULL_LIVES = LIFE_W'(MAX_LIVES);
  localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

  logic [2:0]        state_q, state_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [LIFE_W-1:0] lives_q, lives_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load_q, load_d;
  logic              sel_q;
  logic              pause_q;
  logic              sel_e_s;
  logic              pause_e_s;

  assign sel_e_s   = userSel & ~sel_q;
  assign pause_e_s = pauseBtn & ~pause_q;

  // Next-state, level/lives bookkeeping and hold-screen timing.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    load_d  = 1'b0;
    case (state_q)
      ST_MENU: begin
        if (sel_e_s) begin
          state_d = ST_PLAY;
          level_d = '0;
          lives_d = FULL_LIVES;
          load_d  = 1'b1;
        end else begin
          state_d = ST_MENU;
        end
      end
      ST_PLAY: begin
        if (pause_e_s) begin
          state_d = ST_PAUSE;
        end else if (win && !dead) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (dead && !win) begin
          state_d = ST_LOSE;
          cnt_d   = '0;
          // Guard keeps lives from wrapping even if dead arrives with zero lives.
          lives_d = (lives_q != '0) ? (lives_q - LIFE_W'(1)) : '0;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_PAUSE: begin
        if (sel_e_s) begin
          state_d = ST_MENU;
        end else if (pause_e_s) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == HOLD_LAST) begin
          if (level_q == LAST_LEVEL) begin
            state_d = ST_WIN;
          end else begin
            state_d = ST_PLAY;
            level_d = level_q + LVL_W'(1);
            load_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOSE: begin
        if (cnt_q == HOLD_LAST) begin
          if (lives_q == '0) begin
            state_d = ST_GAMEOVER;
          end else begin
            state_d = ST_PLAY;
            load_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAMEOVER, ST_WIN: begin
        if (sel_e_s) begin
          state_d = ST_MENU;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_MENU;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_MENU;
      level_q <= '0;
      lives_q <= FULL_LIVES;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      sel_q   <= 1'b0;
      pause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      sel_q   <= userSel;
      pause_q <= pauseBtn;
    end
  end

  assign menuScreen  = (state_q == ST_MENU);
  assign playEn      = (state_q == ST_PLAY);
  assign pauseScreen = (state_q == ST_PAUSE);
  assign clearScreen = (state_q == ST_CLEAR);
  assign loseScreen  = (state_q == ST_LOSE);
  assign overScreen  = (state_q == ST_GAMEOVER);
  assign winScreen   = (state_q == ST_WIN);
  assign levelLoad   = load_q;
  assign level       = level_q;
  assign lives       = lives_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: table-driven short sequences plus hand-written
// hold-screen, life-loss and mid-game reset sequences, checked via a scoreboard.
module tb_game_flow_ctrl;

  localparam logic [6:0] S_MENU  = 7'b0000001;
  localparam logic [6:0] S_PLAY  = 7'b0000010;
  localparam logic [6:0] S_PAUSE = 7'b0000100;
  localparam logic [6:0] S_CLEAR = 7'b0001000;
  localparam logic [6:0] S_LOSE  = 7'b0010000;
  localparam logic [6:0] S_OVER  = 7'b0100000;
  localparam logic [6:0] S_WIN   = 7'b1000000;

  typedef struct {
    logic       rst_n;
    logic       sel;
    logic       pau;
    logic       win;
    logic       dead;
    logic [6:0] scr;
    logic       ld;
    logic [1:0] lvl;
    logic [1:0] liv;
  } vec_t;

  typedef struct {
    logic [6:0] scr;
    logic       ld;
    logic [1:0] lvl;
    logic [1:0] liv;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, userSel, pauseBtn, win, dead;
  logic       menuScreen, playEn, pauseScreen, clearScreen, loseScreen;
  logic       overScreen, winScreen, levelLoad;
  logic [1:0] level;
  logic [1:0] lives;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  vec_t tbl[$];

  game_flow_ctrl #(.NUM_LEVELS(3), .MAX_LIVES(3), .HOLD_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .userSel(userSel), .pauseBtn(pauseBtn),
    .win(win), .dead(dead), .menuScreen(menuScreen), .playEn(playEn),
    .pauseScreen(pauseScreen), .clearScreen(clearScreen), .loseScreen(loseScreen),
    .overScreen(overScreen), .winScreen(winScreen), .levelLoad(levelLoad),
    .level(level), .lives(lives)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic r, s, p, w, d, input logic [6:0] scr,
                             input logic ld, input logic [1:0] lvl, liv);
    vec_t t;
    t.rst_n = r; t.sel = s; t.pau = p; t.win = w; t.dead = d;
    t.scr = scr; t.ld = ld; t.lvl = lvl; t.liv = liv;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    logic [6:0] scr;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: got no entry expected one");
    end else begin
      e = sb_q.pop_front();
      scr = {winScreen, overScreen, loseScreen, clearScreen, pauseScreen, playEn, menuScreen};
      chk("screens", 32'(scr), 32'(e.scr));
      chk("levelLoad", 32'(levelLoad), 32'(e.ld));
      chk("level", 32'(level), 32'(e.lvl));
      chk("lives", 32'(lives), 32'(e.liv));
    end
  endtask

  task automatic step(input vec_t t);
    exp_t e;
    @(negedge clk);
    reset = t.rst_n; userSel = t.sel; pauseBtn = t.pau; win = t.win; dead = t.dead;
    e.scr = t.scr; e.ld = t.ld; e.lvl = t.lvl; e.liv = t.liv;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  // Remaining cycles of a hold screen after its entry cycle; inputs are noise.
  task automatic hold_rest(input int n, input logic [6:0] scr, input logic [1:0] lvl, liv);
    for (int i = 0; i < n; i++) begin
      if (i < n - 1)
        step(v(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), scr, 1'b0, lvl, liv));
      else
        step(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, scr, 1'b0, lvl, liv));
    end
  endtask

  initial begin
    reset = 1'b0; userSel = 1'b0; pauseBtn = 1'b0; win = 1'b0; dead = 1'b0;

    tbl.push_back(v(0,0,0,0,0, S_MENU, 0, 2'd0, 2'd3));
    tbl.push_back(v(0,0,0,0,0, S_MENU, 0, 2'd0, 2'd3));
    tbl.push_back(v(1,1,0,0,0, S_PLAY, 1, 2'd0, 2'd3));
    for (int i = 0; i < 9; i++) tbl.push_back(v(1,1,0,0,0, S_PLAY, 0, 2'd0, 2'd3));
    tbl.push_back(v(1,0,0,0,0, S_PLAY,  0, 2'd0, 2'd3));
    tbl.push_back(v(1,0,1,0,0, S_PAUSE, 0, 2'd0, 2'd3));
    tbl.push_back(v(1,0,0,0,0, S_PAUSE, 0, 2'd0, 2'd3));
    tbl.push_back(v(1,0,0,0,1, S_PAUSE, 0, 2'd0, 2'd3));
    tbl.push_back(v(1,0,0,0,0, S_PAUSE, 0, 2'd0, 2'd3));
    tbl.push_back(v(1,0,1,0,0, S_PLAY,  0, 2'd0, 2'd3));
    tbl.push_back(v(1,0,0,0,0, S_PLAY,  0, 2'd0, 2'd3));
    tbl.push_back(v(1,0,0,1,1, S_PLAY,  0, 2'd0, 2'd3));
    tbl.push_back(v(1,0,0,0,0, S_PLAY,  0, 2'd0, 2'd3));
    tbl.push_back(v(1,0,1,1,0, S_PAUSE, 0, 2'd0, 2'd3));
    tbl.push_back(v(1,0,0,0,0, S_PAUSE, 0, 2'd0, 2'd3));
    tbl.push_back(v(1,1,1,0,0, S_MENU,  0, 2'd0, 2'd3));
    tbl.push_back(v(1,0,0,0,0, S_MENU,  0, 2'd0, 2'd3));
    tbl.push_back(v(1,1,0,0,0, S_PLAY,  1, 2'd0, 2'd3));
    tbl.push_back(v(1,0,0,0,0, S_PLAY,  0, 2'd0, 2'd3));

    foreach (tbl[i]) step(tbl[i]);

    // Three level clears ending on the win screen, then back to the menu.
    for (int l = 0; l < 3; l++) begin
      step(v(1,0,0,1,0, S_CLEAR, 0, 2'(l), 2'd3));
      hold_rest(49, S_CLEAR, 2'(l), 2'd3);
      if (l < 2) begin
        step(v(1,0,0,0,0, S_PLAY, 1, 2'(l + 1), 2'd3));
        step(v(1,0,0,0,0, S_PLAY, 0, 2'(l + 1), 2'd3));
      end else begin
        step(v(1,0,0,0,0, S_WIN, 0, 2'd2, 2'd3));
        step(v(1,0,0,0,0, S_WIN, 0, 2'd2, 2'd3));
      end
    end
    step(v(1,1,0,0,0, S_MENU, 0, 2'd2, 2'd3));
    step(v(1,0,0,0,0, S_MENU, 0, 2'd2, 2'd3));

    // Lose all three lives and land on game over.
    step(v(1,1,0,0,0, S_PLAY, 1, 2'd0, 2'd3));
    step(v(1,0,0,0,0, S_PLAY, 0, 2'd0, 2'd3));
    for (int k = 2; k >= 0; k--) begin
      step(v(1,0,0,0,1, S_LOSE, 0, 2'd0, 2'(k)));
      hold_rest(49, S_LOSE, 2'd0, 2'(k));
      if (k > 0) begin
        step(v(1,0,0,0,0, S_PLAY, 1, 2'd0, 2'(k)));
        step(v(1,0,0,0,0, S_PLAY, 0, 2'd0, 2'(k)));
      end else begin
        step(v(1,0,0,0,0, S_OVER, 0, 2'd0, 2'd0));
        step(v(1,0,0,0,0, S_OVER, 0, 2'd0, 2'd0));
      end
    end
    step(v(1,1,0,0,0, S_MENU, 0, 2'd0, 2'd0));
    step(v(1,0,0,0,0, S_MENU, 0, 2'd0, 2'd0));

    // Reset asserted mid-way through a lose hold on level 1.
    step(v(1,1,0,0,0, S_PLAY, 1, 2'd0, 2'd3));
    step(v(1,0,0,0,0, S_PLAY, 0, 2'd0, 2'd3));
    step(v(1,0,0,1,0, S_CLEAR, 0, 2'd0, 2'd3));
    hold_rest(49, S_CLEAR, 2'd0, 2'd3);
    step(v(1,0,0,0,0, S_PLAY, 1, 2'd1, 2'd3));
    step(v(1,0,0,0,0, S_PLAY, 0, 2'd1, 2'd3));
    step(v(1,0,0,0,1, S_LOSE, 0, 2'd1, 2'd2));
    hold_rest(19, S_LOSE, 2'd1, 2'd2);
    step(v(0,0,0,0,0, S_MENU, 0, 2'd0, 2'd3));
    step(v(1,0,0,0,0, S_MENU, 0, 2'd0, 2'd3));
    step(v(1,1,0,0,0, S_PLAY, 1, 2'd0, 2'd3));

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
